// File: rtl/fmc_pixel_unpacker.sv
// fmc_pixel_unpacker: pops packed camera words {fval, lval, dval, data} from a
// FWFT FIFO, splits each word into PIX_PER_BEAT-pixel beats with x/y tags,
// crops to H_RES x V_RES, counts frames and flags lines of the wrong length.
module fmc_pixel_unpacker #(
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned PIX_PER_WORD = 8,
  parameter int unsigned PIX_PER_BEAT = 2,
  parameter int unsigned H_RES        = 512,
  parameter int unsigned V_RES        = 512,
  parameter int unsigned COORD_WIDTH  = 10,
  parameter int unsigned FCNT_W       = 16
) (
  input  logic                              i_clk_500,
  input  logic                              i_rst_n,
  input  logic                              i_fifo_empty,
  input  logic [PIX_W*PIX_PER_WORD+2:0]     i_fifo_dout,
  output logic                              o_fifo_rd_en,
  output logic                              o_pixel_valid,
  input  logic                              i_pixel_ready,
  output logic [PIX_W*PIX_PER_BEAT-1:0]     o_pixel_data,
  output logic [COORD_WIDTH-1:0]            o_pixel_x,
  output logic [COORD_WIDTH-1:0]            o_pixel_y,
  output logic                              o_frame_done,
  output logic [FCNT_W-1:0]                 o_frame_count,
  output logic                              o_line_err,
  output logic                              o_sync_fval,
  output logic                              o_sync_lval
);

  localparam int unsigned IN_W    = PIX_W * PIX_PER_WORD;
  localparam int unsigned BEAT_DW = PIX_W * PIX_PER_BEAT;
  localparam int unsigned BEATS   = PIX_PER_WORD / PIX_PER_BEAT;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW1     = COORD_WIDTH + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_UNPACK = 1'b1;

  // Registered state
  logic [0:0]             state;
  logic [BEAT_W-1:0]      beat;
  logic [IN_W-1:0]        word_q;
  logic [COORD_WIDTH-1:0] x_q;
  logic [COORD_WIDTH-1:0] y_q;
  logic                   prev_fval;
  logic                   prev_lval;

  // Next-state values
  logic [0:0]             state_nxt;
  logic [BEAT_W-1:0]      beat_nxt;
  logic [IN_W-1:0]        word_nxt;
  logic [COORD_WIDTH-1:0] x_nxt;
  logic [COORD_WIDTH-1:0] y_nxt;
  logic                   prev_fval_nxt;
  logic                   prev_lval_nxt;
  logic                   valid_nxt;
  logic [BEAT_DW-1:0]     data_nxt;
  logic [COORD_WIDTH-1:0] px_nxt;
  logic [COORD_WIDTH-1:0] py_nxt;
  logic                   done_nxt;
  logic [FCNT_W-1:0]      fcnt_nxt;
  logic                   lerr_nxt;
  logic                   sfval_nxt;
  logic                   slval_nxt;

  // FIFO word fields
  logic            in_fval;
  logic            in_lval;
  logic            in_dval;
  logic [IN_W-1:0] in_data;

  assign in_fval = i_fifo_dout[IN_W+2];
  assign in_lval = i_fifo_dout[IN_W+1];
  assign in_dval = i_fifo_dout[IN_W];
  assign in_data = i_fifo_dout[IN_W-1:0];

  // Beat slices of the captured word, beat 0 holds the lowest pixels
  logic [BEAT_DW-1:0] word_beats [BEATS];
  for (genvar g = 0; g < BEATS; g++) begin : g_slice
    assign word_beats[g] = word_q[g*BEAT_DW +: BEAT_DW];
  end

  // Saturating coordinate increments
  logic [CW1-1:0]         x_sum;
  logic [CW1-1:0]         y_sum;
  logic [COORD_WIDTH-1:0] x_inc;
  logic [COORD_WIDTH-1:0] y_inc;

  assign x_sum = {1'b0, x_q} + CW1'(PIX_PER_BEAT);
  assign y_sum = {1'b0, y_q} + CW1'(1);
  assign x_inc = x_sum[COORD_WIDTH] ? '1 : x_sum[COORD_WIDTH-1:0];
  assign y_inc = y_sum[COORD_WIDTH] ? '1 : y_sum[COORD_WIDTH-1:0];

  // Output register is held while the consumer stalls; pops are blocked in reset
  logic stall_c;
  logic pop_c;

  assign stall_c      = o_pixel_valid && !i_pixel_ready;
  assign pop_c        = i_rst_n && (state == S_IDLE) && !i_fifo_empty && !stall_c;
  assign o_fifo_rd_en = pop_c;

  // Next-state, coordinate tracking and output beat selection
  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    word_nxt      = word_q;
    x_nxt         = x_q;
    y_nxt         = y_q;
    prev_fval_nxt = prev_fval;
    prev_lval_nxt = prev_lval;
    valid_nxt     = o_pixel_valid;
    data_nxt      = o_pixel_data;
    px_nxt        = o_pixel_x;
    py_nxt        = o_pixel_y;
    done_nxt      = 1'b0;
    fcnt_nxt      = o_frame_count;
    lerr_nxt      = 1'b0;
    sfval_nxt     = o_sync_fval;
    slval_nxt     = o_sync_lval;

    if (o_pixel_valid && i_pixel_ready) begin
      valid_nxt = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (pop_c) begin
          sfval_nxt     = in_fval;
          slval_nxt     = in_lval;
          prev_fval_nxt = in_fval;
          prev_lval_nxt = in_lval;
          // Line end inside an active frame; the frame's fval may fall on the same word
          if (prev_fval && prev_lval && !in_lval) begin
            lerr_nxt = (x_q != COORD_WIDTH'(H_RES));
            x_nxt    = '0;
            y_nxt    = y_inc;
          end
          // Frame start overrides the line increment
          if (in_fval && !prev_fval) begin
            x_nxt = '0;
            y_nxt = '0;
          end
          if (!in_fval && prev_fval) begin
            done_nxt = 1'b1;
            fcnt_nxt = o_frame_count + FCNT_W'(1);
          end
          if (in_fval && in_lval && in_dval) begin
            word_nxt  = in_data;
            beat_nxt  = '0;
            state_nxt = S_UNPACK;
          end
        end
      end
      S_UNPACK: begin
        if (!stall_c) begin
          if ((x_q < COORD_WIDTH'(H_RES)) && (y_q < COORD_WIDTH'(V_RES))) begin
            valid_nxt = 1'b1;
            data_nxt  = word_beats[beat];
            px_nxt    = x_q;
            py_nxt    = y_q;
          end
          // x keeps counting past H_RES so an overlong line is detectable
          x_nxt = x_inc;
          if (beat == BEAT_W'(BEATS - 1)) begin
            state_nxt = S_IDLE;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk_500 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      beat          <= '0;
      word_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      prev_fval     <= 1'b0;
      prev_lval     <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_pixel_data  <= '0;
      o_pixel_x     <= '0;
      o_pixel_y     <= '0;
      o_frame_done  <= 1'b0;
      o_frame_count <= '0;
      o_line_err    <= 1'b0;
      o_sync_fval   <= 1'b0;
      o_sync_lval   <= 1'b0;
    end else begin
      state         <= state_nxt;
      beat          <= beat_nxt;
      word_q        <= word_nxt;
      x_q           <= x_nxt;
      y_q           <= y_nxt;
      prev_fval     <= prev_fval_nxt;
      prev_lval     <= prev_lval_nxt;
      o_pixel_valid <= valid_nxt;
      o_pixel_data  <= data_nxt;
      o_pixel_x     <= px_nxt;
      o_pixel_y     <= py_nxt;
      o_frame_done  <= done_nxt;
      o_frame_count <= fcnt_nxt;
      o_line_err    <= lerr_nxt;
      o_sync_fval   <= sfval_nxt;
      o_sync_lval   <= slval_nxt;
    end
  end

endmodule

// File: doc/fmc_pixel_unpacker.md
Name: fmc_pixel_unpacker

Overview:
Parametrised successor to the camera-side unpacking stage. It sits in the i_clk_500 domain after the async CDC FIFO (FWFT). It pops packed camera words carrying {fval, lval, dval, data}, splits each word into output beats of PIX_PER_BEAT pixels, and tags each beat with x/y coordinates. Compared with the previous generation it adds:
- generic pixel and beat widths
- ready/valid backpressure on the output
- V_RES cropping
- a frame counter
- line-length error detection

Parameters:
PIX_W, 8, bits per pixel
PIX_PER_WORD, 8, pixels per FIFO word; IN_W = PIX_W*PIX_PER_WORD
PIX_PER_BEAT, 2, pixels per output beat; must divide PIX_PER_WORD; BEATS = PIX_PER_WORD/PIX_PER_BEAT
H_RES, 512, active pixels per line
V_RES, 512, active lines per frame
COORD_WIDTH, 10, width of x/y counters; must hold H_RES+PIX_PER_WORD
FCNT_W, 16, frame counter width

Ports:
i_clk_500  in  1  sole clock
i_rst_n  in  1  asynchronous active-low reset
i_fifo_empty  in  1  FIFO empty (FWFT: i_fifo_dout valid when low)
i_fifo_dout  in  IN_W+3  {fval, lval, dval, data}; pixel 0 in data[PIX_W-1:0]
o_fifo_rd_en  out  1  pop strobe, combinational
o_pixel_valid  out  1  beat valid
i_pixel_ready  in  1  downstream accept
o_pixel_data  out  PIX_W*PIX_PER_BEAT  beat pixels; lowest x in the LSBs
o_pixel_x  out  COORD_WIDTH  x of the beat's first pixel
o_pixel_y  out  COORD_WIDTH  line index
o_frame_done  out  1  1-cycle pulse on fval falling edge
o_frame_count  out  FCNT_W  completed frames, wraps
o_line_err  out  1  1-cycle pulse: line ended with x != H_RES
o_sync_fval  out  1  last popped fval
o_sync_lval  out  1  last popped lval

Behaviour:
- Reset: asynchronous. All outputs, state, x, y, prev_fval, prev_lval and the captured word clear to 0. state=IDLE. An in-flight word is discarded. No pop occurs while reset is asserted.
- States:
  - IDLE: waits for a FIFO word.
  - UNPACK: emits BEATS beats from the captured word using a beat index 0..BEATS-1.
- o_fifo_rd_en = (state==IDLE) && !i_fifo_empty && !(o_pixel_valid && !i_pixel_ready).
- On a pop:
  - Register fval/lval to o_sync_*.
  - fval rising: x=0, y=0.
  - fval falling: o_frame_done=1 next cycle; o_frame_count+1 (wraps modulo 2^FCNT_W).
  - lval falling while fval=1: if x != H_RES, pulse o_line_err; then x=0, y=y+1.
  - prev_* update on every pop.
  - If fval&lval&dval: capture data, beat=0, go to UNPACK. Otherwise stay in IDLE.
  - Edge events and capture resolve in the same cycle. Frame reset takes priority over the line increment.
- UNPACK, per beat (advances only when the output register is free or being accepted this cycle):
  - If x < H_RES and y < V_RES: load o_pixel_data = data slice[beat], o_pixel_x = x, o_pixel_y = y, and set o_pixel_valid=1.
  - Otherwise the beat is dropped with no valid.
  - x always increments by PIX_PER_BEAT, so overrun is countable for line_err.
  - beat==BEATS-1 returns to IDLE.
- Output handshake: a beat transfers when valid&&ready. While valid&&!ready, data/x/y are stable and nothing pops or advances. o_pixel_valid clears after acceptance if no new beat is loaded.
- Latency: first beat valid 2 cycles after the pop cycle. Unstalled throughput is one word per BEATS+1 cycles.
- Words popped with fval=0 and lval&dval=1 are dropped.
- x saturates at 2^COORD_WIDTH-1. y saturates likewise.

Test Plan:
- Defaults except H_RES=16, V_RES=4. Pop fval rise, then word 0x0706050403020100 (lval,dval) -> beats 0x0100/x0, 0x0302/x2, 0x0504/x4, 0x0706/x6, all y=0.
- Hold i_pixel_ready=0 for 5 cycles on beat 2 -> data 0x0302, x=2 stable, o_fifo_rd_en=0 throughout. Release -> remaining beats follow in order, no loss.
- Line of 3 words (24 px) with H_RES=16 -> 8 beats x=0..14 output, last 4 dropped, o_line_err pulses at lval fall, y becomes 1.
- 6 lines in one frame with V_RES=4 -> lines y=4,5 produce no valid. fval fall -> o_frame_done single pulse, o_frame_count 0->1.
- Single word with fval and lval both falling -> one o_line_err/y++ and one o_frame_done in the same cycle. Next fval rise -> x=y=0.
- Assert i_rst_n=0 mid-UNPACK (beat 1) -> o_pixel_valid=0 immediately, state IDLE, counters 0. After release, the next word is unpacked from beat 0.
